// File: rtl/des_byte_queue.sv
// rtl/des_byte_queue.sv - byte FIFO behind the deserializer with ack handshake and dequeue port
// Optional build macro: DES_QUEUE_UNDERFLOW_ERR_EN adds a sticky err_out flag for dequeue-while-empty.
`timescale 1ns/1ps

module des_byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clock_100KHz,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_ready_in,
  output logic                       ack_out,
  input  logic                       deq_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH):0]     len_out,
  output logic                       full_out,
`ifdef DES_QUEUE_UNDERFLOW_ERR_EN
  output logic                       empty_out,
  output logic                       err_out
`else
  output logic                       empty_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;

  logic             w_full;
  logic             w_empty;
  logic             w_do_enq;
  logic             w_do_deq;

  // Status is decoded from the occupancy held at the start of the cycle.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign len_out   = r_count;
  assign full_out  = w_full;
  assign empty_out = w_empty;

  // A word is taken only from IDLE, so a full queue simply leaves the deserializer waiting.
  assign w_do_enq = (r_state == S_IDLE) && data_ready_in && !w_full;
  assign w_do_deq = deq_in && !w_empty;

  // Ack is a pure state decode so an async reset removes it at once.
  assign ack_out        = (r_state == S_ACK);
  assign data_out       = r_data_out;
  assign data_valid_out = r_data_valid;

  // Enqueue handshake state register.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Enqueue handshake next state: capture, pulse ack once, then wait for data_ready to clear.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_do_enq) begin
          w_next_state = S_ACK;
        end
      end
      S_ACK: begin
        w_next_state = S_DROP;
      end
      S_DROP: begin
        if (!data_ready_in) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Storage array; contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clock_100KHz) begin
    if (w_do_enq) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Write pointer; power-of-two depth makes the natural rollover the wrap.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_do_enq) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  // Read pointer advances only on an accepted dequeue.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
    end else if (w_do_deq) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy; simultaneous enqueue and dequeue cancel out.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output word register and its one-cycle valid pulse; an ignored dequeue holds data_out.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_do_deq;
      if (w_do_deq) begin
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef DES_QUEUE_UNDERFLOW_ERR_EN
  logic r_err;

  assign err_out = r_err;

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (deq_in && w_empty) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule
